// File: rtl/key_debounce_pkg.sv
// Shared FSM state type, counter-width helpers and 50 MHz timing defaults
// for the multi-channel key debouncer.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } key_state_e;

   localparam int DEF_CH_NUM     = 32'sd4;
   localparam int DEF_CNT_MAX    = 32'sd999_999;
   localparam int DEF_LONG_MAX   = 32'sd49_999_999;
   localparam int DEF_REPEAT_MAX = 32'sd9_999_999;

   function automatic int cnt_width(input int max_val);
      return (max_val < 32'sd1) ? 32'sd1 : $clog2(max_val + 32'sd1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key bank bus: raw key pins in, debounced level and event pulses out.
interface key_debounce_multi_if #(
   parameter int CH_NUM = key_debounce_pkg::DEF_CH_NUM
);
   logic [CH_NUM-1:0] key_in;
   logic [CH_NUM-1:0] key_level;
   logic [CH_NUM-1:0] key_press;
   logic [CH_NUM-1:0] key_release;
   logic [CH_NUM-1:0] key_long;
   logic [CH_NUM-1:0] key_repeat;

   modport master (
      output key_in,
      input  key_level, key_press, key_release, key_long, key_repeat
   );

   modport slave (
      input  key_in,
      output key_level, key_press, key_release, key_long, key_repeat
   );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, symmetric stability filter and
// press/held state machine producing registered one-cycle event pulses.
module key_debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int CNT_MAX    = DEF_CNT_MAX,
   parameter int LONG_MAX   = DEF_LONG_MAX,
   parameter int REPEAT_MAX = DEF_REPEAT_MAX,
   parameter bit REPEAT_EN  = 1'b1,
   parameter bit KEY_ACTIVE = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);
   localparam int CNT_W  = cnt_width(CNT_MAX);
   localparam int HOLD_W = cnt_width(max2(LONG_MAX, REPEAT_MAX));
   localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(CNT_MAX);
   localparam logic [HOLD_W-1:0] LONG_END = HOLD_W'(LONG_MAX);
   localparam logic [HOLD_W-1:0] REP_END  = HOLD_W'(REPEAT_MAX);

   logic              r_sync1, r_sync2, r_level;
   logic [CNT_W-1:0]  r_cnt;
   logic [HOLD_W-1:0] r_hold, w_hold_nx;
   key_state_e        r_state, w_state_nx;
   logic              r_press, r_release, r_long, r_repeat;
   logic              w_press, w_release, w_long, w_repeat;
   logic              w_sample, w_flip, w_rise, w_fall;

   assign w_sample = r_sync2 ^ ~KEY_ACTIVE;
   assign w_flip   = (w_sample != r_level) && (r_cnt == CNT_END);
   assign w_rise   = w_flip & w_sample;
   assign w_fall   = w_flip & ~w_sample;

   // Reset loads the released level so a key held through reset shows up as a fresh press.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= ~KEY_ACTIVE;
         r_sync2 <= ~KEY_ACTIVE;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (w_sample == r_level) begin
         r_cnt   <= '0;
      end else if (w_flip) begin
         r_cnt   <= '0;
         r_level <= ~r_level;
      end else begin
         r_cnt   <= r_cnt + CNT_W'(1'b1);
      end
   end

   // Release is tested first so it wins over a coinciding long/repeat threshold.
   always_comb begin
      w_state_nx = r_state;
      w_hold_nx  = r_hold;
      w_press    = 1'b0;
      w_release  = 1'b0;
      w_long     = 1'b0;
      w_repeat   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nx = ST_PRESSED;
               w_hold_nx  = '0;
               w_press    = 1'b1;
            end else begin
               w_hold_nx  = '0;
            end
         end
         ST_PRESSED: begin
            if (w_fall) begin
               w_state_nx = ST_IDLE;
               w_release  = 1'b1;
            end else if (r_hold == LONG_END) begin
               w_state_nx = ST_HELD;
               w_hold_nx  = '0;
               w_long     = 1'b1;
            end else begin
               w_hold_nx  = r_hold + HOLD_W'(1'b1);
            end
         end
         ST_HELD: begin
            if (w_fall) begin
               w_state_nx = ST_IDLE;
               w_release  = 1'b1;
            end else if (r_hold == REP_END) begin
               if (REPEAT_EN) begin
                  w_repeat  = 1'b1;
                  w_hold_nx = '0;
               end else begin
                  w_hold_nx = r_hold;
               end
            end else begin
               w_hold_nx  = r_hold + HOLD_W'(1'b1);
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_hold_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_hold    <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_hold    <= w_hold_nx;
         r_press   <= w_press;
         r_release <= w_release;
         r_long    <= w_long;
         r_repeat  <= w_repeat;
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: one independent key_debounce_ch per key pin,
// outputs gathered onto the key bank bus.
module key_debounce_multi
   import key_debounce_pkg::*;
#(
   parameter int CH_NUM     = DEF_CH_NUM,
   parameter int CNT_MAX    = DEF_CNT_MAX,
   parameter int LONG_MAX   = DEF_LONG_MAX,
   parameter int REPEAT_MAX = DEF_REPEAT_MAX,
   parameter bit REPEAT_EN  = 1'b1,
   parameter bit KEY_ACTIVE = 1'b0
) (
   input logic                 sys_clk,
   input logic                 sys_rst,
   key_debounce_multi_if.slave bus
);
   logic [CH_NUM-1:0] w_level, w_press, w_release, w_long, w_repeat;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      key_debounce_ch #(
         .CNT_MAX    (CNT_MAX),
         .LONG_MAX   (LONG_MAX),
         .REPEAT_MAX (REPEAT_MAX),
         .REPEAT_EN  (REPEAT_EN),
         .KEY_ACTIVE (KEY_ACTIVE)
      ) u_ch (
         .i_clk     (sys_clk),
         .i_rst     (sys_rst),
         .i_key     (bus.key_in[g]),
         .o_level   (w_level[g]),
         .o_press   (w_press[g]),
         .o_release (w_release[g]),
         .o_long    (w_long[g]),
         .o_repeat  (w_repeat[g])
      );
   end

   assign bus.key_level   = w_level;
   assign bus.key_press   = w_press;
   assign bus.key_release = w_release;
   assign bus.key_long    = w_long;
   assign bus.key_repeat  = w_repeat;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi: directed timing scenarios plus a
// randomized run against a behavioural reference model.
module tb_key_debounce_multi;
   localparam int CH   = 4;
   localparam int CNT  = 7;
   localparam int LONG = 20;
   localparam int REP  = 5;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   key_debounce_multi_if #(.CH_NUM(CH)) ifa ();
   key_debounce_multi_if #(.CH_NUM(CH)) ifb ();
   assign ifb.key_in = ifa.key_in;

   key_debounce_multi #(
      .CH_NUM(CH), .CNT_MAX(CNT), .LONG_MAX(LONG), .REPEAT_MAX(REP),
      .REPEAT_EN(1'b1), .KEY_ACTIVE(1'b0)
   ) dut_a (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ifa));

   key_debounce_multi #(
      .CH_NUM(CH), .CNT_MAX(CNT), .LONG_MAX(LONG), .REPEAT_MAX(REP),
      .REPEAT_EN(1'b0), .KEY_ACTIVE(1'b0)
   ) dut_b (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ifb));

   always #5 sys_clk = ~sys_clk;

   logic [5*CH-1:0] obs_a, obs_b;
   assign obs_a = {ifa.key_level, ifa.key_press, ifa.key_release, ifa.key_long, ifa.key_repeat};
   assign obs_b = {ifb.key_level, ifb.key_press, ifb.key_release, ifb.key_long, ifb.key_repeat};

   // Reference model: pressed sample is the raw pin two edges ago; level flips after
   // CNT+1 consecutive differing samples; long/repeat derived from time since press.
   bit m_h1 [CH];
   bit m_h2 [CH];
   bit m_lvl[CH];
   int m_run[CH];
   int m_t  [CH];
   logic [CH-1:0] e_lvl, e_pr, e_rl, e_lg, e_rp;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_h1[c] = 1'b0; m_h2[c] = 1'b0; m_lvl[c] = 1'b0;
         m_run[c] = 0; m_t[c] = -1;
      end
      e_lvl = '0; e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
   endtask

   task automatic model_step(input logic [CH-1:0] raw);
      for (int c = 0; c < CH; c++) begin
         bit smp;
         smp = m_h2[c];
         m_h2[c] = m_h1[c];
         m_h1[c] = ~raw[c];
         e_pr[c] = 1'b0; e_rl[c] = 1'b0; e_lg[c] = 1'b0; e_rp[c] = 1'b0;
         m_run[c] = (smp != m_lvl[c]) ? m_run[c] + 1 : 0;
         if (m_run[c] == CNT + 1) begin
            m_lvl[c] = ~m_lvl[c];
            m_run[c] = 0;
            if (m_lvl[c]) begin
               e_pr[c] = 1'b1; m_t[c] = 0;
            end else begin
               e_rl[c] = 1'b1; m_t[c] = -1;
            end
         end else if (m_t[c] >= 0) begin
            m_t[c] = m_t[c] + 1;
            if (m_t[c] == LONG + 1) e_lg[c] = 1'b1;
            else if (m_t[c] > LONG + 1 && (m_t[c] - LONG - 1) % (REP + 1) == 0) e_rp[c] = 1'b1;
         end
         e_lvl[c] = m_lvl[c];
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic test_reset();
      ifa.key_in = 4'hF;
      sys_rst    = 1'b1;
      tick(3);
      n_total++;
      if (obs_a !== 20'h0) $display("FAIL reset_a got %h want %h", obs_a, 20'h0);
      else n_pass++;
      n_total++;
      if (obs_b !== 20'h0) $display("FAIL reset_b got %h want %h", obs_b, 20'h0);
      else n_pass++;
      sys_rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge sys_clk);
         n_total++;
         if (obs_a !== 20'h0) $display("FAIL reset_idle k=%0d got %h want %h", k, obs_a, 20'h0);
         else n_pass++;
      end
   endtask

   task automatic test_clean_press();
      logic [19:0] exp;
      ifa.key_in[0] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge sys_clk);
         exp = {((k >= 10) ? 4'b0001 : 4'b0000), ((k == 10) ? 4'b0001 : 4'b0000), 12'h000};
         n_total++;
         if (obs_a !== exp) $display("FAIL clean_press k=%0d got %h want %h", k, obs_a, exp);
         else n_pass++;
      end
      ifa.key_in[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge sys_clk);
         exp = {((k < 10) ? 4'b0001 : 4'b0000), 4'b0000, ((k == 10) ? 4'b0001 : 4'b0000), 8'h00};
         n_total++;
         if (obs_a !== exp) $display("FAIL clean_release k=%0d got %h want %h", k, obs_a, exp);
         else n_pass++;
      end
      tick(5);
   endtask

   task automatic test_bounce();
      for (int k = 0; k < 40; k++) begin
         ifa.key_in[1] = ((k < 6) || (k >= 8 && k < 15)) ? 1'b0 : 1'b1;
         @(negedge sys_clk);
         n_total++;
         if (obs_a !== 20'h0) $display("FAIL bounce k=%0d got %h want %h", k, obs_a, 20'h0);
         else n_pass++;
      end
   endtask

   task automatic test_long_repeat();
      logic [19:0] exp_a, exp_b;
      logic lv, pr, rl, lg, rp;
      for (int k = 1; k <= 140; k++) begin
         ifa.key_in[2] = (k >= 112) ? 1'b1 : 1'b0;
         @(negedge sys_clk);
         lv = (k >= 10 && k < 121);
         pr = (k == 10);
         rl = (k == 121);
         lg = (k == 31);
         rp = (k >= 37 && k < 121 && (k - 37) % 6 == 0);
         exp_a = {1'b0, lv, 2'b00, 1'b0, pr, 2'b00, 1'b0, rl, 2'b00, 1'b0, lg, 2'b00, 1'b0, rp, 2'b00};
         exp_b = {1'b0, lv, 2'b00, 1'b0, pr, 2'b00, 1'b0, rl, 2'b00, 1'b0, lg, 2'b00, 4'b0000};
         n_total++;
         if (obs_a !== exp_a) $display("FAIL long_repeat k=%0d got %h want %h", k, obs_a, exp_a);
         else n_pass++;
         n_total++;
         if (obs_b !== exp_b) $display("FAIL long_norepeat k=%0d got %h want %h", k, obs_b, exp_b);
         else n_pass++;
      end
   endtask

   task automatic test_simultaneous();
      logic [19:0] exp;
      ifa.key_in = 4'b0110;
      for (int k = 1; k <= 12; k++) begin
         @(negedge sys_clk);
         exp = {((k >= 10) ? 4'b1001 : 4'b0000), ((k == 10) ? 4'b1001 : 4'b0000), 12'h000};
         n_total++;
         if (obs_a !== exp) $display("FAIL simultaneous k=%0d got %h want %h", k, obs_a, exp);
         else n_pass++;
      end
      ifa.key_in = 4'b1111;
      for (int k = 1; k <= 12; k++) begin
         @(negedge sys_clk);
         exp = {((k < 10) ? 4'b1001 : 4'b0000), 4'b0000, ((k == 10) ? 4'b1001 : 4'b0000), 8'h00};
         n_total++;
         if (obs_a !== exp) $display("FAIL simultaneous_rel k=%0d got %h want %h", k, obs_a, exp);
         else n_pass++;
      end
      tick(5);
   endtask

   task automatic test_reset_mid_hold();
      logic [19:0] exp;
      ifa.key_in[2] = 1'b0;
      tick(40);
      n_total++;
      if (ifa.key_level !== 4'b0100) $display("FAIL held_level got %h want %h", ifa.key_level, 4'b0100);
      else n_pass++;
      #2 sys_rst = 1'b1;
      #1;
      n_total++;
      if (obs_a !== 20'h0) $display("FAIL async_reset_a got %h want %h", obs_a, 20'h0);
      else n_pass++;
      n_total++;
      if (obs_b !== 20'h0) $display("FAIL async_reset_b got %h want %h", obs_b, 20'h0);
      else n_pass++;
      tick(3);
      sys_rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge sys_clk);
         exp = {((k >= 10) ? 4'b0100 : 4'b0000), ((k == 10) ? 4'b0100 : 4'b0000), 12'h000};
         n_total++;
         if (obs_a !== exp) $display("FAIL reset_repress k=%0d got %h want %h", k, obs_a, exp);
         else n_pass++;
      end
      ifa.key_in[2] = 1'b1;
      tick(15);
   endtask

   task automatic test_random();
      logic [CH-1:0] raw;
      int            dur[CH];
      logic [19:0]   exp_a, exp_b;
      raw = 4'hF;
      ifa.key_in = raw;
      sys_rst = 1'b1;
      tick(2);
      sys_rst = 1'b0;
      model_reset();
      for (int c = 0; c < CH; c++) dur[c] = int'($urandom_range(1, 30));
      for (int n = 0; n < 4000; n++) begin
         for (int c = 0; c < CH; c++) begin
            dur[c] = dur[c] - 1;
            if (dur[c] <= 0) begin
               raw[c] = ~raw[c];
               dur[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 9))
                                                    : int'($urandom_range(10, 150));
            end
         end
         ifa.key_in = raw;
         @(negedge sys_clk);
         model_step(raw);
         exp_a = {e_lvl, e_pr, e_rl, e_lg, e_rp};
         exp_b = {e_lvl, e_pr, e_rl, e_lg, 4'b0000};
         n_total++;
         if (obs_a !== exp_a) $display("FAIL random_a n=%0d got %h want %h", n, obs_a, exp_a);
         else n_pass++;
         n_total++;
         if (obs_b !== exp_b) $display("FAIL random_b n=%0d got %h want %h", n, obs_b, exp_b);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_repeat();
      test_simultaneous();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel successor to the single-key 20 ms debouncer in the HDMI_TOP user-input path. Each channel synchronises its raw key, filters it with a symmetric stability counter, and reports a debounced level. It also emits one-cycle press, release, long-press and auto-repeat pulses. The block feeds the mode/parameter-select logic so that one instance serves the whole key bank.

## Interface
- CH_NUM, 4: number of independent key channels (1..16)
- CNT_MAX, 999_999: stability count; the debounced level flips after CNT_MAX+1 consecutive differing samples (20 ms at 50 MHz)
- LONG_MAX, 49_999_999: cycles held after press before the long-press pulse fires (1 s at 50 MHz)
- REPEAT_MAX, 9_999_999: auto-repeat period in cycles once in long-press (200 ms)
- REPEAT_EN, 1: 1 = auto-repeat enabled; 0 = no key_repeat pulses
- KEY_ACTIVE, 0: raw pressed level (0 = active-low keys)
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst  input  1  asynchronous, active-high reset
- key_in  input  CH_NUM  raw asynchronous key pins
- key_level  output  CH_NUM  debounced level, 1 = pressed (polarity normalised)
- key_press  output  CH_NUM  one-cycle pulse on debounced press
- key_release  output  CH_NUM  one-cycle pulse on debounced release
- key_long  output  CH_NUM  one-cycle pulse when the hold reaches LONG_MAX
- key_repeat  output  CH_NUM  one-cycle pulse every REPEAT_MAX cycles while in long-press

## Operation
- Per channel: 2-flop synchroniser, then XOR with ~KEY_ACTIVE so that sample=1 means pressed.
- Stability counter (width $clog2(CNT_MAX+1)):
  - Clears when sample == key_level.
  - Otherwise increments.
  - When counter == CNT_MAX and sample != key_level: key_level toggles and the counter clears.
  - A glitch shorter than CNT_MAX+1 cycles never changes key_level.
- Per-channel FSM (encoding in package): IDLE, PRESSED, HELD.
  - IDLE -> PRESSED on the debounced press; key_press=1 and hold_cnt cleared in that same cycle.
  - PRESSED: hold_cnt increments. When hold_cnt == LONG_MAX -> HELD, key_long=1, hold_cnt cleared.
  - HELD: hold_cnt increments. When REPEAT_EN and hold_cnt == REPEAT_MAX -> key_repeat=1, hold_cnt cleared, stay in HELD. When REPEAT_EN=0, hold_cnt saturates.
  - PRESSED or HELD -> IDLE on the debounced release; key_release=1.
- Release has priority: if release coincides with a long or repeat threshold, only key_release fires.
- hold_cnt width is $clog2(max(LONG_MAX,REPEAT_MAX)+1). Compares are exact equality and never wrap.
- Channels are fully independent. Simultaneous events on different channels all report in the same cycle.

## Timing
- Reset (async assert, sync release):
  - Synchroniser flops load the inactive level (~KEY_ACTIVE).
  - Counters = 0, FSM = IDLE.
  - All five outputs = 0.
  - A key held down through reset reports key_press CNT_MAX+3 cycles after reset deassertion; it never reports a release first.
- Latency from a raw edge held stable to the key_level change: 2 (sync) + CNT_MAX+1 cycles.
- key_press/key_release are registered and coincide with the first cycle key_level shows the new value.
- key_long asserts LONG_MAX+1 cycles after the key_press cycle.
- The first key_repeat asserts REPEAT_MAX+1 cycles after key_long; later repeats follow at the same spacing.
- Reset mid-hold: all pulses are suppressed and the channel returns to IDLE immediately.

## Structure
- Package key_debounce_pkg holds:
  - the FSM state typedef (IDLE/PRESSED/HELD)
  - width functions (clog2-based)
  - default timing constants for 50 MHz
- Sub-module key_debounce_ch implements one channel (synchroniser, stability counter, FSM).
- The top generates CH_NUM instances and concatenates the outputs.

## Test plan
Bench parameters: CNT_MAX=7, LONG_MAX=20, REPEAT_MAX=5, KEY_ACTIVE=0, CH_NUM=4.
1. Clean press: drive key_in[0] low at t0 and hold. key_level[0] rises at t0+10, with key_press[0] high for 1 cycle at t0+10. No other channel toggles.
2. Bounce: pulse key_in[1] low for 6 cycles, high for 2, low for 7, then high. key_level[1] stays 0 and no pulses appear.
3. Long + repeat: hold key_in[2] low. Expect key_press at P, key_long at P+21, key_repeat at P+27, P+33, P+39. On release, key_release fires once and no repeat occurs after it.
4. REPEAT_EN=0 variant: hold key_in[2] low for 100 cycles. Exactly one key_long and zero key_repeat.
5. Simultaneous: press channels 0 and 3 on the same edge. key_press[0] and key_press[3] assert in the same cycle.
6. Reset mid-hold: assert sys_rst while ch2 is in HELD. All outputs go to 0 asynchronously. With the key still low after release of reset, key_press[2] fires 10 cycles after deassertion with no key_release.
